pam4_tx_mapper: RTL and testbench



---
 rtl/pam4_pkg.sv | 29 ++
 rtl/pam4_symbol_map.sv | 34 +++
 rtl/pam4_tx_mapper.sv | 100 ++++++++++
 tb/tb_pam4_tx_mapper.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pam4_pkg.sv
// rtl/pam4_pkg.sv - shared PAM4 types, Gray decode and level helper
package pam4_pkg;

   localparam int LEVEL_COUNT = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic logic [1:0] gray2idx(input logic [1:0] pair);
      logic [1:0] idx;
      case (pair)
         2'b00:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         2'b11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   // (2*idx-3)*S/2; the caller truncates to its own output width
   function automatic longint idx2level(input logic [1:0] idx, input int s);
      longint v;
      v = ((2 * longint'(idx) - 3) * longint'(s)) / 2;
      return v;
   endfunction

endpackage

// File: rtl/pam4_symbol_map.sv
// rtl/pam4_symbol_map.sv - combinational Gray pair to signed PAM4 level
// PAM4_PRECODE_EN adds the 1/(1+D) mod-4 precoder state ports.
module pam4_symbol_map
   import pam4_pkg::*;
#(
   parameter int SYMBOL_SEPERATION = 56,
   parameter int OUT_WIDTH         = 40
) (
   input  logic [1:0]                  pair,
`ifdef PAM4_PRECODE_EN
   input  logic [1:0]                  p_prev,
   output logic [1:0]                  p_next,
`endif
   output logic signed [OUT_WIDTH-1:0] level
);

   logic [1:0]         idx;
   logic [1:0]         map_idx;
   logic signed [63:0] lvl64;

   always_comb begin
      idx = gray2idx(pair);
`ifdef PAM4_PRECODE_EN
      // 2-bit subtraction wraps, giving the mod-4 result directly
      map_idx = idx - p_prev;
      p_next  = map_idx;
`else
      map_idx = idx;
`endif
      lvl64 = idx2level(map_idx, SYMBOL_SEPERATION);
      level = lvl64[OUT_WIDTH-1:0];
   end

endmodule

// File: rtl/pam4_tx_mapper.sv
// rtl/pam4_tx_mapper.sv - serialize words into Gray-coded PAM4 symbols
// PAM4_PRECODE_EN enables the mod-4 precoder register.
module pam4_tx_mapper
   import pam4_pkg::*;
#(
   parameter int SYMBOL_SEPERATION = 56,
   parameter int DATA_WIDTH        = 8,
   parameter int OUT_WIDTH         = 40
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        d_valid,
   output logic                        d_ready,
   input  logic                        sym_en,
   output logic signed [OUT_WIDTH-1:0] symbol,
   output logic                        s_valid,
   output logic                        busy,
   output logic                        underrun
);

   localparam int SYMS_PER_WORD = DATA_WIDTH / 2;
   localparam int CNT_W = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS_PER_WORD - 1);

   state_t                      state, next_state;
   logic [DATA_WIDTH-1:0]       shreg;
   logic [CNT_W-1:0]            cnt;
   logic                        last_pair;
   logic                        load;
   logic                        emit;
   logic signed [OUT_WIDTH-1:0] level;
`ifdef PAM4_PRECODE_EN
   logic [1:0]                  p_reg;
   logic [1:0]                  p_next;
`endif

   pam4_symbol_map #(
      .SYMBOL_SEPERATION(SYMBOL_SEPERATION),
      .OUT_WIDTH        (OUT_WIDTH)
   ) u_map (
      .pair  (shreg[DATA_WIDTH-1 -: 2]),
`ifdef PAM4_PRECODE_EN
      .p_prev(p_reg),
      .p_next(p_next),
`endif
      .level (level)
   );

   assign emit      = (state == SEND) && sym_en;
   assign last_pair = emit && (cnt == LAST_CNT);
   assign d_ready   = (state == IDLE) || last_pair;
   assign load      = d_valid && d_ready;
   assign busy      = (state == SEND);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (d_valid) next_state = SEND;
         SEND:    if (last_pair) next_state = d_valid ? SEND : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         cnt      <= '0;
         symbol   <= '0;
         s_valid  <= 1'b0;
         underrun <= 1'b0;
`ifdef PAM4_PRECODE_EN
         p_reg    <= 2'b00;
`endif
      end else begin
         state   <= next_state;
         s_valid <= 1'b0;
         if (emit) begin
            symbol  <= level;
            s_valid <= 1'b1;
            shreg   <= {shreg[DATA_WIDTH-3:0], 2'b00};
            cnt     <= last_pair ? '0 : cnt + 1'b1;
`ifdef PAM4_PRECODE_EN
            p_reg   <= p_next;
`endif
         end
         if ((state == IDLE) && sym_en) begin
            symbol   <= '0;
            underrun <= 1'b1;
         end
         // A load on the last-pair edge overrides the shift for gapless words
         if (load) begin
            shreg <= data_in;
            cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pam4_tx_mapper.sv
// tb/tb_pam4_tx_mapper.sv - directed self-checking bench for pam4_tx_mapper
module tb_pam4_tx_mapper;

   logic               clk = 1'b0;
   logic               rst;
   logic [7:0]         data_in;
   logic               d_valid;
   logic               d_ready;
   logic               sym_en;
   logic signed [39:0] symbol;
   logic               s_valid;
   logic               busy;
   logic               underrun;

   int n_tests = 0;
   int n_fail  = 0;

   int e1[4];
   int e2a[4];
   int e2b[4];
   int e3[4];
   int e6[4];

   pam4_tx_mapper #(
      .SYMBOL_SEPERATION(56),
      .DATA_WIDTH       (8),
      .OUT_WIDTH        (40)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .d_valid (d_valid),
      .d_ready (d_ready),
      .sym_en  (sym_en),
      .symbol  (symbol),
      .s_valid (s_valid),
      .busy    (busy),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
`ifdef PAM4_PRECODE_EN
      e1  = '{84, 84, 28, 28};
      e2a = '{28, -84, 28, -84};
      e2b = '{-84, -84, -84, -84};
      e3  = '{-84, -28, -28, 28};
      e6  = '{-28, -84, -28, -84};
`else
      e1  = '{84, 28, -28, -84};
      e2a = '{28, 28, 28, 28};
      e2b = '{-84, -84, -84, -84};
      e3  = '{-84, -28, 28, 84};
      e6  = '{-28, -28, -28, -28};
`endif
      data_in = 8'h00;
      d_valid = 1'b0;
      sym_en  = 1'b0;
      do_reset();
      chk("rst_symbol", $signed(symbol), 0);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_d_ready", d_ready, 1);

      // single word 10_11_01_00
      data_in = 8'hB4;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      chk("w1_busy", busy, 1);
      chk("w1_d_ready_idle_send", d_ready, 0);
      sym_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("w1_d_ready_%0d", k), d_ready, (k == 3) ? 1 : 0);
         tick();
         chk($sformatf("w1_sym_%0d", k), $signed(symbol), e1[k]);
         chk($sformatf("w1_sv_%0d", k), s_valid, 1);
      end
      sym_en = 1'b0;
      chk("w1_idle_busy", busy, 0);
      tick();
      chk("w1_idle_sv", s_valid, 0);
      chk("w1_idle_hold", $signed(symbol), e1[3]);
      chk("w1_no_underrun", underrun, 0);

      // back-to-back FF then 00
      do_reset();
      data_in = 8'hFF;
      d_valid = 1'b1;
      tick();
      data_in = 8'h00;
      sym_en  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b_d_ready_%0d", k), d_ready, (k == 3) ? 1 : 0);
         tick();
         chk($sformatf("b2b_a_sym_%0d", k), $signed(symbol), e2a[k]);
         chk($sformatf("b2b_a_sv_%0d", k), s_valid, 1);
      end
      d_valid = 1'b0;
      chk("b2b_busy_gapless", busy, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("b2b_b_sym_%0d", k), $signed(symbol), e2b[k]);
         chk($sformatf("b2b_b_sv_%0d", k), s_valid, 1);
      end
      sym_en = 1'b0;
      chk("b2b_end_busy", busy, 0);

      // sparse strobe on 00_01_11_10
      do_reset();
      data_in = 8'h1E;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sym_en = 1'b1;
         tick();
         sym_en = 1'b0;
         chk($sformatf("sp_sym_%0d", k), $signed(symbol), e3[k]);
         chk($sformatf("sp_sv_%0d", k), s_valid, 1);
         tick();
         chk($sformatf("sp_hold1_%0d", k), $signed(symbol), e3[k]);
         chk($sformatf("sp_sv_lo1_%0d", k), s_valid, 0);
         tick();
         chk($sformatf("sp_hold2_%0d", k), $signed(symbol), e3[k]);
      end
      chk("sp_end_busy", busy, 0);
      chk("sp_no_underrun", underrun, 0);

      // underrun after reset, sticky, cleared by reset
      do_reset();
      sym_en = 1'b1;
      tick();
      sym_en = 1'b0;
      chk("ur_set", underrun, 1);
      chk("ur_symbol", $signed(symbol), 0);
      chk("ur_sv", s_valid, 0);
      tick();
      chk("ur_sticky", underrun, 1);
      do_reset();
      chk("ur_cleared", underrun, 0);

      // load and sym_en in same IDLE cycle, word 01_01_01_01
      data_in = 8'h55;
      d_valid = 1'b1;
      sym_en  = 1'b1;
      tick();
      d_valid = 1'b0;
      chk("ls_underrun", underrun, 1);
      chk("ls_busy", busy, 1);
      chk("ls_sv", s_valid, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("pc_sym_%0d", k), $signed(symbol), e6[k]);
         chk($sformatf("pc_sv_%0d", k), s_valid, 1);
      end
      sym_en = 1'b0;

      // reset mid-word discards remaining pairs
      do_reset();
      data_in = 8'hB4;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      sym_en  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("mw_sym_%0d", k), $signed(symbol), e1[k]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sym_en = 1'b0;
      chk("mw_symbol", $signed(symbol), 0);
      chk("mw_sv", s_valid, 0);
      chk("mw_busy", busy, 0);
      chk("mw_d_ready", d_ready, 1);
      sym_en = 1'b1;
      tick();
      sym_en = 1'b0;
      chk("mw_no_emit_sym", $signed(symbol), 0);
      chk("mw_no_emit_sv", s_valid, 0);
      chk("mw_underrun", underrun, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
